mem_slave_16x8: RTL and testbench



---
 rtl/mem_slave_16x8.sv | 100 ++++++++++
 tb/tb_mem_slave_16x8.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mem_slave_16x8.sv
// -----------------------------------------------------------------------------
// mem_slave_16x8
//
// Responder for a small synchronous memory bus: a 2**ADDR_WIDTH x DATA_WIDTH
// array with a single request port. Each rising edge decodes {wr_en, rd_en}:
//   00 idle, 10 write, 01 read, 11 illegal (neither access is performed).
// Read data is registered and qualified by rvalid one cycle after the request.
// Three saturating counters track completed writes, reads and illegal requests.
//
// Ports:
//   clk        in   single clock, all state updates on the rising edge
//   reset      in   synchronous, active-high; clears memory, outputs, counters
//   addr       in   access address (every value is a legal location)
//   wr_en      in   write request
//   rd_en      in   read request
//   wdata      in   write data
//   rdata      out  registered read data, held until the next read or reset
//   rvalid     out  rdata was loaded by a read at the previous edge
//   err        out  an illegal (read+write) request was seen at the previous edge
//   wr_count   out  completed writes, saturating
//   rd_count   out  completed reads, saturating
//   err_count  out  illegal requests, saturating
//
// Handshake: there is no back-pressure. A request is accepted on every edge
// where reset is low; rvalid/err are single-cycle strobes for the request
// accepted at the previous edge and are never held waiting for a consumer.
// -----------------------------------------------------------------------------
module mem_slave_16x8 #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  err,
    output logic [CNT_WIDTH-1:0]  wr_count,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic [CNT_WIDTH-1:0]  err_count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        REQ_IDLE    = 2'b00,
        REQ_READ    = 2'b01,
        REQ_WRITE   = 2'b10,
        REQ_ILLEGAL = 2'b11
    } req_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    req_t                  req;

    always_comb begin
        req = req_t'({wr_en, rd_en});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem       <= '{default: '0};
            rdata     <= '0;
            rvalid    <= 1'b0;
            err       <= 1'b0;
            wr_count  <= '0;
            rd_count  <= '0;
            err_count <= '0;
        end else begin
            // Strobes default low; only the matching request raises one.
            rvalid <= 1'b0;
            err    <= 1'b0;
            case (req)
                REQ_WRITE: begin
                    mem[addr] <= wdata;
                    if (wr_count != CNT_MAX) wr_count <= wr_count + CNT_ONE;
                end
                REQ_READ: begin
                    // Read and write never share a cycle, so no bypass is
                    // needed: the array already holds any earlier write.
                    rdata  <= mem[addr];
                    rvalid <= 1'b1;
                    if (rd_count != CNT_MAX) rd_count <= rd_count + CNT_ONE;
                end
                REQ_ILLEGAL: begin
                    err <= 1'b1;
                    if (err_count != CNT_MAX) err_count <= err_count + CNT_ONE;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_slave_16x8.sv
// -----------------------------------------------------------------------------
// tb_mem_slave_16x8
//
// Self-checking bench for mem_slave_16x8: a table of directed vectors with
// hand-computed expected outputs, followed by hand-written sequences for
// counter saturation, back-to-back reads and reset in the middle of traffic.
// -----------------------------------------------------------------------------
module tb_mem_slave_16x8;

    logic       clk;
    logic       reset;
    logic [3:0] addr;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       rvalid;
    logic       err;
    logic [7:0] wr_count;
    logic [7:0] rd_count;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];

    typedef struct {
        logic       rst;
        logic       wr;
        logic       rd;
        logic [3:0] a;
        logic [7:0] wd;
        logic [7:0] e_rdata;
        logic       e_rvalid;
        logic       e_err;
        logic [7:0] e_wc;
        logic [7:0] e_rc;
        logic [7:0] e_ec;
    } vec_t;

    vec_t vecs[$];

    mem_slave_16x8 dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .wdata     (wdata),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .err       (err),
        .wr_count  (wr_count),
        .rd_count  (rd_count),
        .err_count (err_count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    // Drive one request, let one rising edge consume it, then settle 1 unit so
    // the outputs of that edge can be sampled away from the clock.
    task automatic apply(input logic r, input logic w, input logic rd_i,
                         input logic [3:0] a, input logic [7:0] d);
        reset = r;
        wr_en = w;
        rd_en = rd_i;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic add_vec(input logic r, input logic w, input logic rd_i,
                           input logic [3:0] a, input logic [7:0] d,
                           input logic [7:0] er, input logic ev, input logic ee,
                           input logic [7:0] ewc, input logic [7:0] erc,
                           input logic [7:0] eec);
        vec_t v;
        v.rst = r; v.wr = w; v.rd = rd_i; v.a = a; v.wd = d;
        v.e_rdata = er; v.e_rvalid = ev; v.e_err = ee;
        v.e_wc = ewc; v.e_rc = erc; v.e_ec = eec;
        vecs.push_back(v);
    endtask

    // ---------------- stimulus + scoreboard ----------------
    initial begin
        logic [7:0] exp_data;
        int         last_i;

        reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0;

        // Reset state, then read every address of the cleared array.
        add_vec(1, 0, 0, 4'd0, 8'h00, 8'h00, 0, 0, 8'd0, 8'd0, 8'd0);
        add_vec(1, 0, 0, 4'd0, 8'h00, 8'h00, 0, 0, 8'd0, 8'd0, 8'd0);
        for (int i = 0; i < 16; i++)
            add_vec(0, 0, 1, 4'(i), 8'h00, 8'h00, 1, 0, 8'd0, 8'(i + 1), 8'd0);
        // Fresh start for write-then-read.
        add_vec(1, 0, 0, 4'd0, 8'h00, 8'h00, 0, 0, 8'd0, 8'd0, 8'd0);
        add_vec(0, 1, 0, 4'd3,  8'hA5, 8'h00, 0, 0, 8'd1, 8'd0, 8'd0);
        add_vec(0, 1, 0, 4'd12, 8'h5A, 8'h00, 0, 0, 8'd2, 8'd0, 8'd0);
        add_vec(0, 1, 0, 4'd15, 8'hFF, 8'h00, 0, 0, 8'd3, 8'd0, 8'd0);
        add_vec(0, 0, 1, 4'd3,  8'h00, 8'hA5, 1, 0, 8'd3, 8'd1, 8'd0);
        add_vec(0, 0, 1, 4'd12, 8'h00, 8'h5A, 1, 0, 8'd3, 8'd2, 8'd0);
        add_vec(0, 0, 1, 4'd15, 8'h00, 8'hFF, 1, 0, 8'd3, 8'd3, 8'd0);
        add_vec(0, 0, 0, 4'd0,  8'h00, 8'hFF, 0, 0, 8'd3, 8'd3, 8'd0);
        // Read after write on the same address, then overwrite.
        add_vec(0, 1, 0, 4'd7, 8'h3C, 8'hFF, 0, 0, 8'd4, 8'd3, 8'd0);
        add_vec(0, 0, 1, 4'd7, 8'h00, 8'h3C, 1, 0, 8'd4, 8'd4, 8'd0);
        add_vec(0, 1, 0, 4'd7, 8'hC3, 8'h3C, 0, 0, 8'd5, 8'd4, 8'd0);
        add_vec(0, 0, 1, 4'd7, 8'h00, 8'hC3, 1, 0, 8'd5, 8'd5, 8'd0);
        // Illegal request twice: no write to addr 2, rdata held.
        add_vec(0, 1, 0, 4'd2, 8'h11, 8'hC3, 0, 0, 8'd6, 8'd5, 8'd0);
        add_vec(0, 1, 1, 4'd2, 8'h99, 8'hC3, 0, 1, 8'd6, 8'd5, 8'd1);
        add_vec(0, 1, 1, 4'd2, 8'h99, 8'hC3, 0, 1, 8'd6, 8'd5, 8'd2);
        add_vec(0, 0, 0, 4'd2, 8'h00, 8'hC3, 0, 0, 8'd6, 8'd5, 8'd2);
        add_vec(0, 0, 1, 4'd2, 8'h00, 8'h11, 1, 0, 8'd6, 8'd6, 8'd2);

        foreach (vecs[k]) begin
            apply(vecs[k].rst, vecs[k].wr, vecs[k].rd, vecs[k].a, vecs[k].wd);
            check($sformatf("vec%0d_rdata", k),     32'(rdata),     32'(vecs[k].e_rdata));
            check($sformatf("vec%0d_rvalid", k),    32'(rvalid),    32'(vecs[k].e_rvalid));
            check($sformatf("vec%0d_err", k),       32'(err),       32'(vecs[k].e_err));
            check($sformatf("vec%0d_wr_count", k),  32'(wr_count),  32'(vecs[k].e_wc));
            check($sformatf("vec%0d_rd_count", k),  32'(rd_count),  32'(vecs[k].e_rc));
            check($sformatf("vec%0d_err_count", k), 32'(err_count), 32'(vecs[k].e_ec));
        end

        // Counter saturation: 300 writes, wr_count climbs to 255 and sticks.
        apply(1, 0, 0, 4'd0, 8'h00);
        for (int i = 0; i < 300; i++) begin
            apply(0, 1, 0, 4'(i % 16), 8'(i));
            check("sat_wr_count", 32'(wr_count), (i + 1 > 255) ? 32'd255 : 32'(i + 1));
        end
        check("sat_rd_count", 32'(rd_count), 32'd0);
        check("sat_err_count", 32'(err_count), 32'd0);

        // Back-to-back reads of what the saturation run left behind: the last
        // write to address a was write number i = largest i < 300 with i%16 == a.
        for (int a = 0; a < 16; a++) begin
            last_i = (288 + a < 300) ? 288 + a : 272 + a;
            exp_data = 8'(last_i);
            exp_q.push_back(exp_data);
        end
        for (int a = 0; a < 16; a++) begin
            apply(0, 0, 1, 4'(a), 8'h00);
            exp_data = exp_q.pop_front();
            check($sformatf("b2b_rdata_a%0d", a), 32'(rdata), 32'(exp_data));
            check($sformatf("b2b_rvalid_a%0d", a), 32'(rvalid), 32'd1);
        end
        check("b2b_rd_count", 32'(rd_count), 32'd16);
        check("b2b_wr_count", 32'(wr_count), 32'd255);

        // Mid-stream reset: pending rvalid is cleared and the read under reset
        // produces nothing; memory and counters restart from zero.
        apply(0, 1, 0, 4'd5, 8'h77);
        apply(0, 0, 1, 4'd5, 8'h00);
        check("mid_pre_rdata", 32'(rdata), 32'h77);
        check("mid_pre_rvalid", 32'(rvalid), 32'd1);
        apply(1, 0, 1, 4'd5, 8'h00);
        check("mid_rst_rvalid", 32'(rvalid), 32'd0);
        check("mid_rst_rdata", 32'(rdata), 32'h00);
        check("mid_rst_wr_count", 32'(wr_count), 32'd0);
        apply(0, 1, 1, 4'd5, 8'h00);
        check("mid_err_after_rst", 32'(err), 32'd1);
        apply(1, 0, 0, 4'd5, 8'h00);
        check("mid_rst_clears_err", 32'(err), 32'd0);
        check("mid_rst_err_count", 32'(err_count), 32'd0);
        apply(0, 0, 1, 4'd5, 8'h00);
        check("mid_read_rdata", 32'(rdata), 32'h00);
        check("mid_read_rvalid", 32'(rvalid), 32'd1);
        check("mid_read_rd_count", 32'(rd_count), 32'd1);
        check("mid_read_wr_count", 32'(wr_count), 32'd0);
        check("mid_read_err_count", 32'(err_count), 32'd0);

        apply(0, 0, 0, 4'd0, 8'h00);
        check("final_rvalid_low", 32'(rvalid), 32'd0);

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
